// File: rtl/sm_extin.sv
// sm_extin: synchronizes and debounces an 8-bit external pin bus into a CPU-readable register
// Ports: clk_i clock; rst_ni async active-low reset; pin_in_i raw pins; ext_ack_i CPU read ack;
//        ext_data_o committed value; ext_new_o sticky update flag; ext_changed_o one-cycle update pulse.
// Macro SM_EXTIN_DEBOUNCE_EN compiles in the debounce FSM; without it sync2 commits directly.
module sm_extin #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic [7:0]  RESET_VALUE     = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] pin_in_i,
   input  logic       ext_ack_i,
   output logic [7:0] ext_data_o,
   output logic       ext_new_o,
   output logic       ext_changed_o
);
   logic [7:0] sync1_q, sync2_q, data_q, data_d;
   logic       new_q, new_d, chg_q, commit;
   if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
      $error("sm_extin: DEBOUNCE_CYCLES must be 1..65535");
   end
`ifdef SM_EXTIN_DEBOUNCE_EN
   typedef enum logic {STABLE, SETTLE} state_t;
   localparam logic [15:0] DC = 16'(DEBOUNCE_CYCLES);
   state_t      state_q, state_d;
   logic [7:0]  cand_q, cand_d;
   logic [15:0] cnt_q, cnt_d;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= STABLE;
         cand_q  <= RESET_VALUE;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end
   // Any new differing value restarts qualification; returning to extData rejects the glitch.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      if (state_q == STABLE) begin
         if (sync2_q != data_q) begin
            state_d = SETTLE;
            cand_d  = sync2_q;
            cnt_d   = 16'd1;
         end
      end else if (sync2_q == data_q) begin
         state_d = STABLE;
      end else if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = 16'd1;
      end else if (cnt_q < DC) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         state_d = STABLE;
      end
   end
   always_comb begin
      commit = state_q == SETTLE && sync2_q == cand_q && sync2_q != data_q && cnt_q == DC;
   end
`else
   always_comb begin
      commit = sync2_q != data_q;
   end
`endif
   // At commit sync2 equals the candidate, so both builds load sync2.
   always_comb begin
      data_d = commit ? sync2_q : data_q;
      new_d  = commit | (new_q & ~ext_ack_i);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= RESET_VALUE;
         sync2_q <= RESET_VALUE;
         data_q  <= RESET_VALUE;
         new_q   <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         sync1_q <= pin_in_i;
         sync2_q <= sync1_q;
         data_q  <= data_d;
         new_q   <= new_d;
         chg_q   <= commit;
      end
   end
   assign ext_data_o    = data_q;
   assign ext_new_o     = new_q;
   assign ext_changed_o = chg_q;
endmodule

// File: tb/tb_sm_extin.sv
// tb_sm_extin: directed self-checking bench for sm_extin with a run-length debounce model
module tb_sm_extin;
   localparam int D = 4;
   localparam logic [7:0] RV = 8'h00;
`ifdef SM_EXTIN_DEBOUNCE_EN
   localparam int NEED = D + 1;
   localparam int LAT  = D + 3;
`else
   localparam int NEED = 1;
   localparam int LAT  = 3;
`endif
   logic       clk_i = 1'b0, rst_ni = 1'b0, ext_ack_i = 1'b0;
   logic [7:0] pin_in_i = 8'h00;
   logic [7:0] ext_data_o;
   logic       ext_new_o, ext_changed_o;
   int errors = 0, checks = 0;
   int pulses = 0;
   logic [7:0] watch = 8'hFF;
   logic seen = 1'b0;

   sm_extin #(.DEBOUNCE_CYCLES(D), .RESET_VALUE(RV)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pin_in_i(pin_in_i), .ext_ack_i(ext_ack_i),
      .ext_data_o(ext_data_o), .ext_new_o(ext_new_o), .ext_changed_o(ext_changed_o)
   );

   always #5 clk_i = ~clk_i;

   // Model: a value commits once NEED consecutive post-sync samples all equal it and differ from extData.
   logic [7:0] m1, m2, mprev, mdata;
   logic       mnew, mchg, mcommit;
   int         mrun, run_nx;
   assign run_nx  = (m2 == mdata) ? 0 : (m2 == mprev) ? mrun + 1 : 1;
   assign mcommit = run_nx == NEED;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m1 <= RV; m2 <= RV; mprev <= RV; mdata <= RV; mrun <= 0; mnew <= 1'b0; mchg <= 1'b0;
      end else begin
         m1    <= pin_in_i;
         m2    <= m1;
         mprev <= m2;
         mrun  <= mcommit ? 0 : run_nx;
         if (mcommit) mdata <= m2;
         mchg  <= mcommit;
         mnew  <= mcommit | (mnew & ~ext_ack_i);
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      chk("model_data", ext_data_o, mdata);
      chk("model_new", {7'd0, ext_new_o}, {7'd0, mnew});
      chk("model_chg", {7'd0, ext_changed_o}, {7'd0, mchg});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
         pulses += int'(ext_changed_o);
         if (ext_data_o == watch) seen = 1'b1;
      end
   endtask

   initial begin
      pin_in_i = 8'h09;
      #12;
      chk("rst_data", ext_data_o, RV);
      chk("rst_new", {7'd0, ext_new_o}, 8'd0);
      chk("rst_chg", {7'd0, ext_changed_o}, 8'd0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      tick(LAT - 1);
      chk("first_before", ext_data_o, 8'h00);
      tick(1);
      chk("first_data", ext_data_o, 8'h09);
      chk("first_chg", {7'd0, ext_changed_o}, 8'd1);
      chk("first_new", {7'd0, ext_new_o}, 8'd1);
      tick(1);
      chk("first_chg_off", {7'd0, ext_changed_o}, 8'd0);
      chk("first_new_hold", {7'd0, ext_new_o}, 8'd1);
      pulses = 0;
      pin_in_i = 8'h0F;
      tick(2);
      pin_in_i = 8'h09;
      tick(10);
      chk("glitch_data", ext_data_o, 8'h09);
`ifdef SM_EXTIN_DEBOUNCE_EN
      chk("glitch_pulses", 8'(pulses), 8'd0);
`else
      chk("glitch_pulses", 8'(pulses), 8'd2);
`endif
      watch = 8'h03;
      seen = 1'b0;
      pin_in_i = 8'h03;
      tick(2);
      pin_in_i = 8'h05;
      tick(LAT - 1);
`ifdef SM_EXTIN_DEBOUNCE_EN
      chk("restart_before", ext_data_o, 8'h09);
`else
      chk("restart_before", ext_data_o, 8'h03);
`endif
      tick(1);
      chk("restart_data", ext_data_o, 8'h05);
`ifdef SM_EXTIN_DEBOUNCE_EN
      chk("restart_seen03", {7'd0, seen}, 8'd0);
`else
      chk("restart_seen03", {7'd0, seen}, 8'd1);
`endif
      watch = 8'hFF;
      tick(2);
      pin_in_i = 8'h0A;
      tick(LAT - 1);
      ext_ack_i = 1'b1;
      tick(1);
      chk("ack_coincide_data", ext_data_o, 8'h0A);
      chk("ack_coincide_new", {7'd0, ext_new_o}, 8'd1);
      tick(1);
      chk("ack_clear_new", {7'd0, ext_new_o}, 8'd0);
      tick(1);
      ext_ack_i = 1'b0;
      tick(1);
      chk("ack_idle_new", {7'd0, ext_new_o}, 8'd0);
      chk("ack_idle_data", ext_data_o, 8'h0A);
      pin_in_i = 8'h11;
      tick(5);
      rst_ni = 1'b0;
      #1;
      chk("midrst_data", ext_data_o, RV);
      chk("midrst_new", {7'd0, ext_new_o}, 8'd0);
      chk("midrst_chg", {7'd0, ext_changed_o}, 8'd0);
      pin_in_i = RV;
      pulses = 0;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      tick(12);
      chk("midrst_after_data", ext_data_o, RV);
      chk("midrst_after_pulses", 8'(pulses), 8'd0);
      pulses = 0;
`ifdef SM_EXTIN_DEBOUNCE_EN
      pin_in_i = 8'h22;
      tick(D);
      pin_in_i = RV;
      tick(10);
      chk("short_pulse_pulses", 8'(pulses), 8'd0);
      pin_in_i = 8'h33;
      tick(D + 1);
      pin_in_i = RV;
      tick(1);
      chk("min_pulse_before", ext_data_o, RV);
      tick(1);
      chk("min_pulse_data", ext_data_o, 8'h33);
`else
      pin_in_i = 8'h22;
      tick(1);
      pin_in_i = RV;
      tick(2);
      chk("one_cycle_data", ext_data_o, 8'h22);
      tick(4);
      chk("one_cycle_pulses", 8'(pulses), 8'd2);
`endif
      tick(10);
      chk("final_data", ext_data_o, RV);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sm_extin.md
SM_EXTIN -- requirements
Module: sm_extin

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: cycles a synchronized value must stay stable before commit; legal range 1..65535.
REQ-002 Parameter RESET_VALUE, default 8'h00: value of extData after reset.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pin_in  input  8  raw asynchronous external switch/pin bus.
REQ-006 extAck  input  1  CPU-side read acknowledge; clears extNew.
REQ-007 extData  output  8  committed input value, registered, drives sm_cpu extData.
REQ-008 extNew  output  1  sticky flag: extData updated since last extAck.
REQ-009 extChanged  output  1  one-cycle pulse on the edge extData is updated.

Function
REQ-010 pin_in SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 is used downstream.
REQ-011 FSM states SHALL be STABLE and SETTLE; 16-bit counter cnt and 8-bit register cand.
REQ-012 In STABLE, when sync2 != extData: cand <= sync2, cnt <= 1, go to SETTLE; otherwise hold.
REQ-013 In SETTLE, when sync2 != cand and sync2 != extData: cand <= sync2, cnt <= 1, stay in SETTLE (restart).
REQ-014 In SETTLE, when sync2 == extData: go to STABLE, no update, no pulse (glitch rejected).
REQ-015 In SETTLE, when sync2 == cand and cnt < DEBOUNCE_CYCLES: cnt <= cnt + 1.
REQ-016 In SETTLE, when sync2 == cand and cnt == DEBOUNCE_CYCLES: extData <= cand, extChanged <= 1 for that cycle, extNew <= 1, go to STABLE.
REQ-017 Latency: a clean pin change SHALL appear on extData exactly DEBOUNCE_CYCLES + 3 rising edges after it is set up before the first edge.
REQ-018 A pulse on pin_in shorter than DEBOUNCE_CYCLES + 1 cycles (after sync) SHALL NOT change extData.
REQ-019 extChanged SHALL be 0 on every cycle not described in REQ-016.
REQ-020 extNew SHALL clear on an edge with extAck = 1; if set condition and extAck coincide, extNew SHALL remain 1.
REQ-021 extAck while extNew = 0 SHALL have no effect.
REQ-022 cnt SHALL never wrap; it saturates at DEBOUNCE_CYCLES.

Reset
REQ-023 While rst_n = 0: sync1, sync2, cand, extData = RESET_VALUE; cnt = 0; extNew = 0; extChanged = 0; state = STABLE.
REQ-024 Reset asserted mid-SETTLE SHALL abandon the candidate; no commit after release unless re-qualified.
REQ-025 First edge after rst_n deassertion SHALL behave as normal operation (no extra pulse on release).

Configuration
REQ-026 Macro SM_EXTIN_DEBOUNCE_EN: when defined, the FSM of REQ-011..REQ-018 and REQ-022 is compiled in.
REQ-027 Without SM_EXTIN_DEBOUNCE_EN: FSM, cand and cnt are absent; on any edge with sync2 != extData, extData <= sync2 with extChanged/extNew as in REQ-016; latency 3 edges; DEBOUNCE_CYCLES ignored.

Verification
REQ-028 Reset, pin_in = 8'h09 held -> extData = 8'h09 at edge 7 after release (debounce, 4), extChanged high one cycle, extNew = 1.
REQ-029 Stable 8'h09, pin_in glitch to 8'h0F for 2 cycles -> extData stays 8'h09, extChanged never asserts.
REQ-030 pin_in 8'h09 -> 8'h03 for 2 cycles -> 8'h05 held -> candidate restarts; extData = 8'h05 exactly 7 edges after 8'h05 applied; 8'h03 never seen.
REQ-031 extNew = 1, extAck pulsed on the same edge as a new commit -> extNew stays 1; next extAck alone -> extNew = 0.
REQ-032 rst_n asserted during SETTLE with cnt = 3 -> all outputs return to RESET_VALUE/0 immediately (asynchronous), no commit after release while pin_in = RESET_VALUE.
REQ-033 Build without SM_EXTIN_DEBOUNCE_EN, pin_in 8'h00 -> 8'hA5 -> extData = 8'hA5 at edge 3, one-cycle 2-cycle glitch propagates to extData.
